// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift operation encodings, shifter FSM states and
// default datapath sizes.
package alu_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    // Shift operation encodings as presented by the ALU control path.
    // op[1] set means the fill bit comes from the MSB (SRA, ROL).
    typedef enum logic [1:0] {
        SH_SLA = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROL = 2'b11
    } shift_op_e;

    // Sequential shifter control states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    // Left-moving operations (SLA, ROL) have op bits that are equal.
    function automatic logic is_left(input shift_op_e op);
        return ~(op[1] ^ op[0]);
    endfunction

endpackage

// File: rtl/mux2to1.sv
// Library 2:1 mux cell: y = sel ? b : a.
module mux2to1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    // Single-bit select.
    always_comb begin
        y = sel ? b : a;
    end

endmodule

// File: rtl/shift_step.sv
// One single-bit shift stage built from mux2to1 cells: one cell per output
// bit picks the left or right neighbour, one cell picks the fill bit, and
// one cell picks the outgoing bit.
module shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] acc,
    input  shift_op_e        op_r,
    output logic [WIDTH-1:0] acc_next,
    output logic             bit_out
);

    logic left;
    logic fill;

    assign left = is_left(op_r);

    // Fill is the MSB for SRA (sign) and ROL (wrap-around), zero otherwise.
    mux2to1 u_fill (
        .a   (1'b0),
        .b   (acc[WIDTH-1]),
        .sel (op_r[1]),
        .y   (fill)
    );

    // Outgoing bit: MSB when moving left, LSB when moving right.
    mux2to1 u_out (
        .a   (acc[0]),
        .b   (acc[WIDTH-1]),
        .sel (left),
        .y   (bit_out)
    );

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            logic from_right;
            logic from_left;

            if (i == 0) begin : g_lsb
                assign from_left = fill;
            end else begin : g_lmid
                assign from_left = acc[i-1];
            end

            if (i == WIDTH - 1) begin : g_msb
                assign from_right = fill;
            end else begin : g_rmid
                assign from_right = acc[i+1];
            end

            mux2to1 u_bit (
                .a   (from_right),
                .b   (from_left),
                .sel (left),
                .y   (acc_next[i])
            );
        end
    endgenerate

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle sequential shifter. One single-bit step per clock in SHIFT
// until the sampled amount is used up, then a one-cycle done pulse.
//
// Handshake: start is a request accepted only on a rising edge where the
// block is IDLE (busy=0); there is no queueing and start is ignored while
// busy=1. done is a one-cycle pulse that marks dout/carry valid; dout and
// carry then hold until the next accept.
module shift_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dout,
    output logic               carry,
    output state_e             state
);

    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] cnt;
    shift_op_e          op_r;
    logic [WIDTH-1:0]   step_acc;
    logic               step_bit;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .op_r     (op_r),
        .acc_next (step_acc),
        .bit_out  (step_bit)
    );

    assign dout = acc;

    // Control FSM with registered busy/done plus the datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            op_r  <= SH_SLA;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc   <= din;
                        cnt   <= shamt;
                        op_r  <= shift_op_e'(op);
                        carry <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt != '0) begin
                        acc   <= step_acc;
                        carry <= step_bit;
                        cnt   <= cnt - 1'b1;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: hand-computed vectors, latency/busy timing,
// back-to-back start, and reset abort.
module tb_shift_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] din;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] dout;
    logic        carry;
    state_e      state;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    logic [31:0] exp_q[$];

    shift_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .din   (din),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .carry (carry),
        .state (state)
    );

    // Clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for the done pulse; returns the edge after which it was
    // seen and how many of the waited cycles had busy high.
    task automatic wait_done(input string tag, output int edge_n, output int busy_n);
        bit seen;
        seen   = 1'b0;
        edge_n = -1;
        busy_n = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (busy) busy_n++;
            if (done) begin
                seen   = 1'b1;
                edge_n = cyc;
            end
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Drive one operation, scramble inputs after accept, check result/timing.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                          input logic [4:0] s, input logic [31:0] ed, input logic ec);
        int t_acc, e_done, busy_n;
        logic [31:0] exp_v;
        @(negedge clk);
        start = 1'b1; op = o; din = d; shamt = s;
        @(posedge clk); #1;
        t_acc = cyc;
        exp_q.push_back(ed);
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        check({tag, "_no_early_done"}, 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0; op = ~o; din = ~d; shamt = ~s;
        wait_done(tag, e_done, busy_n);
        exp_v = exp_q.pop_front();
        check({tag, "_latency"}, 32'(e_done - t_acc + 1), 32'(s) + 32'd2);
        check({tag, "_busy_cycles"}, 32'(busy_n + 1), 32'(s) + 32'd2);
        check({tag, "_dout"}, dout, exp_v);
        check({tag, "_carry"}, 32'(carry), 32'(ec));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        check({tag, "_dout_hold"}, dout, exp_v);
    endtask

    initial begin : main
        int t0, t1, e_done, busy_n, done_cnt;
        bit rose;

        rst = 1'b1; start = 1'b0; op = 2'b00; din = 32'h0; shamt = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_state", 32'(state), 32'(S_IDLE));
        rst = 1'b0;

        run_op("sla31",   2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
        run_op("sra4",    2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0);
        run_op("srl4",    2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0);
        run_op("srl1",    2'b01, 32'h0000_0003, 5'd1,  32'h0000_0001, 1'b1);
        run_op("rol1",    2'b11, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b1);
        run_op("sla0",    2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0);
        run_op("rol4",    2'b11, 32'h1234_5678, 5'd4,  32'h2345_6781, 1'b1);
        run_op("sra1",    2'b10, 32'hF000_0001, 5'd1,  32'hF800_0000, 1'b1);

        // start held high: accepts 5 cycles apart, post-accept input changes ignored
        @(negedge clk);
        start = 1'b1; op = 2'b00; din = 32'h0000_0003; shamt = 5'd2;
        @(posedge clk); #1;
        t0 = cyc;
        check("b2b_busy0", 32'(busy), 32'd1);
        @(negedge clk);
        din = 32'hFFFF_FFFF; shamt = 5'd31;
        wait_done("b2b_a", e_done, busy_n);
        check("b2b_a_latency", 32'(e_done - t0 + 1), 32'd4);
        check("b2b_a_dout", dout, 32'h0000_000C);
        check("b2b_a_carry", 32'(carry), 32'd0);
        @(negedge clk);
        din = 32'h4000_0001; shamt = 5'd2;
        rose = 1'b0;
        t1 = -1;
        for (int i = 0; i < 10 && !rose; i++) begin
            @(posedge clk); #1;
            if (busy) begin
                rose = 1'b1;
                t1 = cyc;
            end
        end
        check("b2b_spacing", 32'(t1 - t0), 32'd5);
        @(negedge clk);
        din = 32'hFFFF_FFFF; shamt = 5'd31;
        wait_done("b2b_b", e_done, busy_n);
        check("b2b_b_dout", dout, 32'h0000_0004);
        check("b2b_b_carry", 32'(carry), 32'd1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;

        // reset overrides start in the same cycle
        @(negedge clk);
        rst = 1'b1; start = 1'b1; din = 32'h1234_5678; shamt = 5'd3;
        @(posedge clk); #1;
        check("rst_ovr_busy", 32'(busy), 32'd0);
        check("rst_ovr_state", 32'(state), 32'(S_IDLE));
        check("rst_ovr_dout", dout, 32'h0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        // reset 3 cycles into a shamt=20 op, then immediate new start
        @(negedge clk);
        start = 1'b1; op = 2'b00; din = 32'hFFFF_FFFF; shamt = 5'd20;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort1_busy", 32'(busy), 32'd0);
        check("abort1_dout", dout, 32'h0);
        check("abort1_carry", 32'(carry), 32'd0);
        check("abort1_done", 32'(done), 32'd0);
        rst = 1'b0;
        run_op("post_rst", 2'b01, 32'hA5A5_0F0F, 5'd8, 32'h00A5_A50F, 1'b0);

        // reset mid-op, then confirm no done ever follows
        @(negedge clk);
        start = 1'b1; op = 2'b00; din = 32'hFFFF_FFFF; shamt = 5'd20;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort2_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_cnt++;
        end
        check("abort2_no_done", 32'(done_cnt), 32'd0);
        run_op("after_idle", 2'b00, 32'h0000_0001, 5'd0, 32'h0000_0001, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle sequential shifter for the 32-bit processor datapath. It accepts an operand, a shift amount and an operation from the ALU control path, then applies a single-bit shift stage once per clock until the amount is exhausted. The final result and the last bit shifted out are returned with a one-cycle `done` pulse. The block trades the area of a full barrel shifter for `shamt + 2` cycles of latency.

## Interface
- `WIDTH`, default 32: operand and result width.
- `SHAMT_W`, default 5: shift-amount width; must equal log2(`WIDTH`).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE.
- `op`  in  2  operation: 00 SLA (left, zero fill), 01 SRL (right, zero fill), 10 SRA (right, sign fill), 11 ROL (rotate left).
- `din`  in  `WIDTH`  operand; sampled on accept.
- `shamt`  in  `SHAMT_W`  shift amount, 0..31; sampled on accept.
- `busy`  out  1  high in SHIFT and DONE states.
- `done`  out  1  one-cycle pulse; result valid.
- `dout`  out  `WIDTH`  result; holds until the next accept.
- `carry`  out  1  last bit shifted or rotated out; 0 when `shamt` = 0.

## Operation
- **States:**
  - IDLE to SHIFT on `start`=1. This is the accept: `acc`<=`din`, `cnt`<=`shamt`, `op_r`<=`op`, `carry`<=0.
  - SHIFT with `cnt`!=0: apply one step to `acc`, `cnt`<=`cnt`-1, and `carry` takes the bit leaving the word.
  - SHIFT to DONE when `cnt`==0.
  - DONE to IDLE unconditionally.
- **One step:**
  - SLA: `acc` = {`acc`[30:0],0}, carry = `acc`[31].
  - SRL: `acc` = {0,`acc`[31:1]}, carry = `acc`[0].
  - SRA: `acc` = {`acc`[31],`acc`[31:1]}, carry = `acc`[0].
  - ROL: `acc` = {`acc`[30:0],`acc`[31]}, carry = `acc`[31].
- `dout` is driven directly from `acc`. `op`, `din` and `shamt` are ignored after the accept.
- `start` is ignored while `busy`=1, including in DONE. There is no queueing, so the requester must wait for `busy`=0.
- `start` is accepted in IDLE on the cycle immediately after `done`.
- `shamt`=0: passes through SHIFT with no step, and `dout`=`din`, `carry`=0.
- `cnt` is `SHAMT_W` wide and never wraps; decrement happens only when nonzero.

## Timing
- Accept on edge t. `done`=1 during cycle t+`shamt`+2, exactly one cycle.
- Throughput: one operation per `shamt`+3 cycles when back-to-back (IDLE cycle included).
- `busy` rises the cycle after the accept and falls the cycle after `done`.
- **Reset:** values after `rst`=1 at an edge:
  - state IDLE
  - `acc`=0, so `dout`=0x0000_0000
  - `cnt`=0, `carry`=0, `busy`=0, `done`=0
- Reset overrides `start` in the same cycle.
- Reset mid-operation aborts the operation with no `done`. A `start` in the first cycle after reset is accepted.

## Structure
- **Shared package (`alu_pkg`):**
  - `op` encodings: SH_SLA, SH_SRL, SH_SRA, SH_ROL.
  - State enum: S_IDLE, S_SHIFT, S_DONE.
  - `WIDTH`/`SHAMT_W` defaults.
- **Sub-module `shift_step`:** combinational, one bit position. Inputs `acc` and `op_r`; outputs the next `acc` and the outgoing bit. It is built from the existing `mux2to1` cells, one per bit plus a fill-bit select.
- **Top level:** state register, counter, `acc`/`carry` registers, handshake decode.

## Test plan
- SLA, `din`=0x0000_0001, `shamt`=31: `dout`=0x8000_0000, `carry`=0, `done` at accept+33.
- SRA, `din`=0x8000_0000, `shamt`=4: `dout`=0xF800_0000, `carry`=0. Repeat as SRL: `dout`=0x0800_0000.
- SRL, `din`=0x0000_0003, `shamt`=1: `dout`=0x0000_0001, `carry`=1. ROL, `din`=0x8000_0001, `shamt`=1: `dout`=0x0000_0003, `carry`=1.
- `shamt`=0, `din`=0xDEAD_BEEF, op SLA: `dout`=0xDEAD_BEEF, `carry`=0, `done` at accept+2, `busy` high for 2 cycles.
- `start` held high continuously, `shamt`=2:
  - Accepts are 5 cycles apart.
  - `start` pulses while `busy` are ignored.
  - `din`/`shamt` changes after the accept do not alter the result.
- `rst` asserted 3 cycles into a `shamt`=20 operation:
  - Next cycle: `busy`=0, `dout`=0, `carry`=0, and no `done` pulse follows.
  - A new `start` the following cycle completes normally.
